// File: rtl/pkt_defs_pkg.sv
// Shared packet word layout, header codes and arbiter state encoding.
package pkt_defs_pkg;
  localparam int PKT_W = 134;

  localparam logic [1:0] HDR_FIRST = 2'b01;
  localparam logic [1:0] HDR_MID   = 2'b11;
  localparam logic [1:0] HDR_LAST  = 2'b10;

  typedef struct packed {
    logic [1:0]   hdr;
    logic [3:0]   ibc;
    logic [127:0] payload;
  } pkt_word_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_DISCARD = 2'd2
  } arb_state_t;

  function automatic logic is_last(input logic [PKT_W-1:0] w);
    pkt_word_t pw;
    pw = w;
    return pw.hdr == HDR_LAST;
  endfunction
endpackage

// File: rtl/pkt_mux2_arb_if.sv
// Word/flag streams of both inputs and the merged output, with per-packet almost-full back-pressure.
interface pkt_mux2_arb_if;
  import pkt_defs_pkg::*;

  logic             in0_data_wr;
  logic [PKT_W-1:0] in0_data;
  logic             in0_valid_wr;
  logic             in0_valid;
  logic             in0_alf;
  logic             in1_data_wr;
  logic [PKT_W-1:0] in1_data;
  logic             in1_valid_wr;
  logic             in1_valid;
  logic             in1_alf;
  logic             pktout_data_wr;
  logic [PKT_W-1:0] pktout_data;
  logic             pktout_valid_wr;
  logic             pktout_valid;
  logic             pktout_alf;

  modport master (
    output in0_data_wr, in0_data, in0_valid_wr, in0_valid,
    output in1_data_wr, in1_data, in1_valid_wr, in1_valid,
    output pktout_alf,
    input  in0_alf, in1_alf,
    input  pktout_data_wr, pktout_data, pktout_valid_wr, pktout_valid
  );

  modport slave (
    input  in0_data_wr, in0_data, in0_valid_wr, in0_valid,
    input  in1_data_wr, in1_data, in1_valid_wr, in1_valid,
    input  pktout_alf,
    output in0_alf, in1_alf,
    output pktout_data_wr, pktout_data, pktout_valid_wr, pktout_valid
  );
endinterface

// File: rtl/pkt_mux2_arb_sync_fifo.sv
// Single-clock FIFO, rdata registered one cycle after rd; writes when full and reads when empty are ignored.
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   usedw,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_wr;
  logic          do_rd;

  assign full  = usedw[AW];
  assign empty = (usedw == '0);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      usedw <= '0;
      rdata <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) begin
        rptr  <= rptr + 1'b1;
        rdata <= mem[rptr];
      end
      usedw <= usedw + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
    end
  end
endmodule

// File: rtl/pkt_mux2_arb.sv
// Two-input packet merger: round-robin whole-packet grant, drop-flagged packets read out silently.
// Words appear 2 cycles after their FIFO read; a new packet starts only while pktout_alf is low.
module pkt_mux2_arb
  import pkt_defs_pkg::*;
#(
  parameter int FIFO_AW    = 8,
  parameter int VFIFO_AW   = 4,
  parameter int ALF_MARGIN = 16
) (
  input  logic          clk,
  input  logic          rst,
  pkt_mux2_arb_if.slave bus,
  output logic [31:0]   in0_pkt_cnt,
  output logic [31:0]   in1_pkt_cnt,
  output logic [15:0]   drop_cnt,
  output logic [15:0]   ovf_cnt
);
  localparam logic [FIFO_AW:0] ALF_THR = (FIFO_AW+1)'((1 << FIFO_AW) - ALF_MARGIN);

  logic [1:0]       d_wr, d_rd, d_full, d_empty, alf;
  logic [1:0]       v_wr, v_rd, v_full, v_empty, v_wdat, v_rdat;
  logic [PKT_W-1:0] d_wdat [2];
  logic [PKT_W-1:0] d_rdat [2];
  logic [FIFO_AW:0] d_used [2];
  logic [VFIFO_AW:0] v_used [2];
  logic             unused_vused;

  // One-entry staging of each valid FIFO head so the grant decision sees the flag directly.
  logic [1:0]       vh_v, vh, vrd_pend, pop;

  arb_state_t       state, state_nx;
  logic             sel, prio, gsel, rd_sel, grant, rd_en, rd_pend, last_seen;
  logic [PKT_W-1:0] rd_word;
  logic [16:0]      ovf_sum;

  assign d_wr      = {bus.in1_data_wr, bus.in0_data_wr};
  assign d_wdat[0] = bus.in0_data;
  assign d_wdat[1] = bus.in1_data;
  assign v_wr      = {bus.in1_valid_wr, bus.in0_valid_wr};
  assign v_wdat    = {bus.in1_valid, bus.in0_valid};
  assign bus.in0_alf = alf[0];
  assign bus.in1_alf = alf[1];
  assign unused_vused = ^{v_used[0], v_used[1]};

  for (genvar g = 0; g < 2; g++) begin : g_in
    sync_fifo #(.W(PKT_W), .AW(FIFO_AW)) u_dfifo (
      .clk(clk), .rst(rst), .wr(d_wr[g]), .wdata(d_wdat[g]), .rd(d_rd[g]),
      .rdata(d_rdat[g]), .usedw(d_used[g]), .full(d_full[g]), .empty(d_empty[g])
    );
    sync_fifo #(.W(1), .AW(VFIFO_AW)) u_vfifo (
      .clk(clk), .rst(rst), .wr(v_wr[g]), .wdata(v_wdat[g]), .rd(v_rd[g]),
      .rdata(v_rdat[g]), .usedw(v_used[g]), .full(v_full[g]), .empty(v_empty[g])
    );
    assign alf[g]  = (d_used[g] >= ALF_THR) || v_full[g];
    assign v_rd[g] = !v_empty[g] && !vrd_pend[g] && (!vh_v[g] || pop[g]);
  end

  assign rd_word   = sel ? d_rdat[1] : d_rdat[0];
  assign last_seen = rd_pend && is_last(rd_word);
  assign d_rd      = {rd_en && rd_sel, rd_en && !rd_sel};
  assign pop       = {grant && gsel, grant && !gsel};
  assign ovf_sum   = {1'b0, ovf_cnt} + 17'(d_wr[0] & d_full[0]) + 17'(d_wr[1] & d_full[1]);

  // The last word is recognised one cycle after its read, which also suppresses the next read.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    gsel     = vh_v[prio] ? prio : ~prio;
    rd_en    = 1'b0;
    rd_sel   = sel;
    case (state)
      ST_IDLE: begin
        if (!bus.pktout_alf && (vh_v != 2'b00)) begin
          grant    = 1'b1;
          rd_sel   = gsel;
          rd_en    = !d_empty[gsel];
          state_nx = vh[gsel] ? ST_SEND : ST_DISCARD;
        end
      end
      ST_SEND, ST_DISCARD: begin
        if (last_seen) state_nx = ST_IDLE;
        else           rd_en    = !d_empty[sel];
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_IDLE;
      sel                 <= 1'b0;
      prio                <= 1'b0;
      rd_pend             <= 1'b0;
      vh_v                <= '0;
      vh                  <= '0;
      vrd_pend            <= '0;
      bus.pktout_data_wr  <= 1'b0;
      bus.pktout_data     <= '0;
      bus.pktout_valid_wr <= 1'b0;
      bus.pktout_valid    <= 1'b0;
      in0_pkt_cnt         <= '0;
      in1_pkt_cnt         <= '0;
      drop_cnt            <= '0;
      ovf_cnt             <= '0;
    end else begin
      state   <= state_nx;
      rd_pend <= rd_en;
      if (grant) begin
        sel  <= gsel;
        prio <= ~gsel;
      end
      vrd_pend <= v_rd;
      for (int i = 0; i < 2; i++) begin
        if (pop[i]) vh_v[i] <= 1'b0;
        if (vrd_pend[i]) begin
          vh_v[i] <= 1'b1;
          vh[i]   <= v_rdat[i];
        end
      end
      bus.pktout_data_wr  <= rd_pend && (state == ST_SEND);
      bus.pktout_valid_wr <= last_seen && (state == ST_SEND);
      bus.pktout_valid    <= last_seen && (state == ST_SEND);
      if (rd_pend && (state == ST_SEND)) bus.pktout_data <= rd_word;
      if (last_seen && (state == ST_SEND)) begin
        if (sel) in1_pkt_cnt <= in1_pkt_cnt + 32'd1;
        else     in0_pkt_cnt <= in0_pkt_cnt + 32'd1;
      end
      if (last_seen && (state == ST_DISCARD) && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
      ovf_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
    end
  end
endmodule

// File: tb/tb_pkt_mux2_arb.sv
// Directed bench for pkt_mux2_arb: scoreboard of expected output words, checked as the DUT emits them.
module tb_pkt_mux2_arb;
  import pkt_defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in0_pkt_cnt, in1_pkt_cnt;
  logic [15:0] drop_cnt, ovf_cnt;
  int          checks = 0;
  int          errors = 0;
  logic [PKT_W-1:0] sb [$];
  logic [PKT_W-1:0] mon_exp;

  pkt_mux2_arb_if bus ();

  pkt_mux2_arb #(.FIFO_AW(8), .VFIFO_AW(4), .ALF_MARGIN(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .in0_pkt_cnt(in0_pkt_cnt), .in1_pkt_cnt(in1_pkt_cnt),
    .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [PKT_W-1:0] mk_word(input int port, input int pkt, input int idx, input int n);
    pkt_word_t w;
    w.hdr     = (idx == n - 1) ? HDR_LAST : ((idx == 0) ? HDR_FIRST : HDR_MID);
    w.ibc     = (idx == n - 1) ? 4'(n % 16) : 4'd0;
    w.payload = {8'(port), 8'(pkt), 16'(idx), 32'hA5C3_0000 ^ 32'(n * 977 + idx),
                 64'(port * 1000003 + pkt * 7919 + idx * 31)};
    return w;
  endfunction

  task automatic expect_pkt(input int port, input int pkt, input int n);
    for (int i = 0; i < n; i++) sb.push_back(mk_word(port, pkt, i, n));
  endtask

  task automatic idle_inputs();
    bus.in0_data_wr = 1'b0; bus.in0_data = '0; bus.in0_valid_wr = 1'b0; bus.in0_valid = 1'b0;
    bus.in1_data_wr = 1'b0; bus.in1_data = '0; bus.in1_valid_wr = 1'b0; bus.in1_valid = 1'b0;
  endtask

  // Drives one packet per input in the same cycles; n=0 leaves that input idle.
  task automatic drive(input int n0, input bit k0, input int id0, input int n1, input bit k1, input int id1);
    int n = (n0 > n1) ? n0 : n1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.in0_data_wr  = (i < n0);
      bus.in0_data     = mk_word(0, id0, i, n0);
      bus.in0_valid_wr = (i == n0 - 1);
      bus.in0_valid    = k0;
      bus.in1_data_wr  = (i < n1);
      bus.in1_data     = mk_word(1, id1, i, n1);
      bus.in1_valid_wr = (i == n1 - 1);
      bus.in1_valid    = k1;
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int k = 0;
    while (sb.size() != 0 && k < bound) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_drain"}, sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.pktout_data_wr) begin
      if (sb.size() == 0) begin
        check("unexpected_word", bus.pktout_data_wr, 1'b0);
      end else begin
        mon_exp = sb.pop_front();
        check("out_word", bus.pktout_data, mon_exp);
        check("out_valid_wr", bus.pktout_valid_wr, is_last(mon_exp));
        if (is_last(mon_exp)) check("out_valid", bus.pktout_valid, 1'b1);
      end
    end else if (bus.pktout_valid_wr) begin
      check("orphan_valid_wr", bus.pktout_valid_wr, 1'b0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    int k;
    rst = 1'b1;
    bus.pktout_alf = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_data_wr", bus.pktout_data_wr, 1'b0);
    check("rst_valid_wr", bus.pktout_valid_wr, 1'b0);
    check("rst_valid", bus.pktout_valid, 1'b0);
    check("rst_data", bus.pktout_data, '0);
    check("rst_in0_cnt", in0_pkt_cnt, 0);
    check("rst_in1_cnt", in1_pkt_cnt, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_ovf", ovf_cnt, 0);
    check("rst_in0_alf", bus.in0_alf, 1'b0);
    check("rst_in1_alf", bus.in1_alf, 1'b0);

    // single 9-word keep packet
    expect_pkt(0, 1, 9);
    drive(9, 1'b1, 1, 0, 1'b0, 0);
    wait_drain("single", 100);
    check("single_in0_cnt", in0_pkt_cnt, 1);

    // 3+3 packets queued behind pktout_alf, then released: strict alternation from input 0
    do_reset();
    bus.pktout_alf = 1'b1;
    for (int p = 0; p < 3; p++) begin
      expect_pkt(0, 30 + p, 6);
      expect_pkt(1, 40 + p, 4);
    end
    for (int p = 0; p < 3; p++) drive(6, 1'b1, 30 + p, 4, 1'b1, 40 + p);
    repeat (10) @(posedge clk);
    #1;
    check("alf_hold_no_out", bus.pktout_data_wr, 1'b0);
    bus.pktout_alf = 1'b0;
    @(posedge clk); #1;
    check("grant_lat_1", bus.pktout_data_wr, 1'b0);
    @(posedge clk); #1;
    check("grant_lat_2", bus.pktout_data_wr, 1'b1);
    wait_drain("rr", 400);
    check("rr_in0_cnt", in0_pkt_cnt, 3);
    check("rr_in1_cnt", in1_pkt_cnt, 3);

    // drop-flagged packet on in1, then a keep packet
    expect_pkt(1, 81, 5);
    drive(0, 1'b0, 0, 5, 1'b0, 80);
    drive(0, 1'b0, 0, 5, 1'b1, 81);
    wait_drain("drop", 100);
    check("drop_cnt", drop_cnt, 1);
    check("drop_in1_cnt", in1_pkt_cnt, 4);

    // flag ahead of its data, words trickling in with gaps
    expect_pkt(0, 50, 5);
    @(posedge clk); #1;
    bus.in0_valid_wr = 1'b1;
    bus.in0_valid    = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    repeat (4) @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.in0_data_wr = 1'b1;
      bus.in0_data    = mk_word(0, 50, i, 5);
      @(posedge clk); #1;
      idle_inputs();
    end
    wait_drain("early_flag", 100);
    check("early_in0_cnt", in0_pkt_cnt, 4);

    // 300 words into in0 with output blocked: almost-full at 240, 44 overflow
    bus.pktout_alf = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (i == 239) check("alf_at_239", bus.in0_alf, 1'b0);
      if (i == 240) check("alf_at_240", bus.in0_alf, 1'b1);
      bus.in0_data_wr = 1'b1;
      bus.in0_data    = mk_word(0, 60, i, 300);
    end
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    check("ovf_cnt", ovf_cnt, 44);
    check("alf_full", bus.in0_alf, 1'b1);
    check("alf_other", bus.in1_alf, 1'b0);
    do_reset();
    bus.pktout_alf = 1'b0;
    check("ovf_after_rst", ovf_cnt, 0);
    check("alf_after_rst", bus.in0_alf, 1'b0);

    // reset in the middle of a 9-word packet
    expect_pkt(0, 90, 9);
    drive(9, 1'b1, 90, 0, 1'b0, 0);
    k = 0;
    while (sb.size() != 5 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("mid_reach_word4", sb.size(), 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_data_wr", bus.pktout_data_wr, 1'b0);
    check("mid_rst_data", bus.pktout_data, '0);
    check("mid_rst_valid_wr", bus.pktout_valid_wr, 1'b0);
    check("mid_rst_in0_cnt", in0_pkt_cnt, 0);
    sb.delete();
    repeat (20) @(posedge clk);
    #1;
    expect_pkt(0, 91, 7);
    drive(7, 1'b1, 91, 0, 1'b0, 0);
    wait_drain("post_rst", 100);
    check("post_rst_in0_cnt", in0_pkt_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pkt_mux2_arb.md
PKT_MUX2_ARB -- requirements
Module: pkt_mux2_arb

Interface
REQ-001 Parameters: FIFO_AW, default 8, is the log2 depth of each input data FIFO (256 x 134).
REQ-002 Parameters: VFIFO_AW, default 4, is the log2 depth of each input valid FIFO (16 x 1).
REQ-003 Parameters: ALF_MARGIN, default 16, is the free-word count at or below which in*_alf asserts.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 inN_data_wr / inN_data (N=0,1)  in  1/134  word strobe and data; [133:132] header (01 first, 11 middle, 10 last), [131:128] invalid-byte count, [127:0] payload.
REQ-007 inN_valid_wr / inN_valid  in  1/1  per-packet keep(1)/drop(0) flag, pulsed with or after the last word.
REQ-008 inN_alf  out  1  almost-full back-pressure to upstream, honoured at packet boundaries.
REQ-009 pktout_data_wr / pktout_data  out  1/134  merged output word stream.
REQ-010 pktout_valid_wr / pktout_valid  out  1/1  per-packet flag on the output, always 1 when pulsed.
REQ-011 pktout_alf  in  1  downstream almost-full; no new packet starts while high.
REQ-012 inN_pkt_cnt  out  32  packets forwarded from input N; wraps modulo 2^32.
REQ-013 drop_cnt / ovf_cnt  out  16/16  discarded packets / words lost to full FIFO, saturating.

Function
REQ-014 Each input SHALL write every inN_data_wr word into its data FIFO and every inN_valid_wr bit into its valid FIFO.
REQ-015 inN_alf SHALL be high when that input's data FIFO free space <= ALF_MARGIN, or when its valid FIFO is full.
REQ-016 A word written while the data FIFO is full SHALL be dropped and SHALL increment ovf_cnt.
REQ-017 FSM states: IDLE, SEND, DISCARD.
REQ-018 In IDLE, when pktout_alf=0 and at least one valid FIFO is non-empty, the FSM SHALL grant round-robin: priority to the input not granted last; after reset, input 0 has priority.
REQ-019 On grant, the FSM SHALL pop the valid bit and enter SEND if it is 1, or DISCARD if it is 0.
REQ-020 SEND SHALL read one data word per cycle and drive it on pktout_data with pktout_data_wr=1; read-to-output latency is 2 cycles (FIFO read plus output register).
REQ-021 On the output cycle of a word with header 10, the block SHALL assert pktout_valid_wr=1 and pktout_valid=1, increment inN_pkt_cnt, and return to IDLE.
REQ-022 DISCARD SHALL read words through header 10 with pktout_data_wr held at 0, increment drop_cnt, and return to IDLE.
REQ-023 Grant SHALL be held for a whole packet; pktout_alf asserting mid-packet SHALL NOT stall it.
REQ-024 Packet-to-packet: the next grant is evaluated in the cycle after the last word is read; the minimum output gap is 1 idle cycle.
REQ-025 Simultaneous writes on both inputs and an output read of the same FIFO in one cycle SHALL all be honoured with no loss.
REQ-026 A valid bit present before its packet's last word is in the data FIFO SHALL NOT stall the FSM; SEND pauses its reads while that data FIFO is empty.

Reset
REQ-027 rst SHALL empty all FIFOs, set the FSM to IDLE, and give round-robin priority to input 0.
REQ-028 rst SHALL drive pktout_data_wr, pktout_valid_wr, pktout_valid, and all counters to 0, pktout_data to 134'h0, and inN_alf to 0.
REQ-029 rst asserted mid-packet SHALL abort it; no further output words appear.

Structure
REQ-030 Header codes (01/11/10), the 134-bit width, and the FSM state encoding SHALL live in the shared package pkt_defs_pkg.
REQ-031 The one sub-module SHALL be sync_fifo (parameterised width and depth, registered read, usedw/full/empty), instantiated four times.

Verification
REQ-032 Scenario: one 9-word keep packet on in0 -> 9 identical words on pktout; valid_wr=1 with valid=1 on the 10-1 word; in0_pkt_cnt=1.
REQ-033 Scenario: in0 and in1 each present 3 packets simultaneously -> output order 0,1,0,1,0,1; no word interleaving within a packet.
REQ-034 Scenario: in1 packet with valid=0 -> no pktout_data_wr; drop_cnt=1; the following keep packet is forwarded intact.
REQ-035 Scenario: pktout_alf held at 1 with packets queued -> no output; release -> output begins 2 cycles after the grant.
REQ-036 Scenario: write 300 words to in0 with the output blocked -> in0_alf high at 240 used words; ovf_cnt=44.
REQ-037 Scenario: rst pulsed during word 4 of 9 -> outputs zero on the next cycle; FIFOs empty; a subsequent packet is forwarded correctly.
